// File: rtl/ad9361_pkg.sv
// rtl/ad9361_pkg.sv - shared widths, pairing states and sign extension for the AD9361 RX packer
//
// Purpose: common definitions used by the RX pair packer and its stream interface.
//   SAMPLE_W : raw converter sample width
//   COMP_W   : width of one packed component after sign extension
//   PACK_W   : width of one packed dual-channel word {q1, i1, q0, i0}
package ad9361_pkg;

    localparam int SAMPLE_W = 12;
    localparam int COMP_W   = 16;
    localparam int PACK_W   = 64;

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } pair_state_e;

    function automatic logic [COMP_W-1:0] sign_ext(input logic [SAMPLE_W-1:0] s);
        return {{(COMP_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/ad9361_rx_pair_packer_if.sv
// rtl/ad9361_rx_pair_packer_if.sv - packed-word ready/valid stream toward capture/DMA logic
//
// Purpose: carries packed dual-channel words out of the RX pair packer.
// Signals:
//   m_data  : packed word {q1, i1, q0, i0}, 16 bits each
//   m_valid : m_data holds a word
//   m_ready : consumer accepts; a word moves when m_valid && m_ready
// Modports: master (packer side), slave (consumer side).
interface ad9361_rx_pair_packer_if;
    import ad9361_pkg::*;

    logic [PACK_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/ad9361_sync_fifo.sv
// rtl/ad9361_sync_fifo.sv - generic single-clock first-word-fall-through FIFO with count
//
// Purpose: buffers words between a push side and a registered ready/valid output.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   s_tdata/s_tvalid  : push side; a word is written when s_tvalid && s_tready
//   s_tready          : high while count < DEPTH (a same-cycle pop does not help)
//   m_tdata/m_tvalid  : registered output word
//   m_tready          : consumer accepts; pop when m_tvalid && m_tready
//   count             : occupancy, output register included
module ad9361_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [WIDTH-1:0]         m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      mem_count_q, mem_count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             push, pop, load;

    always_comb begin
        count       = mem_count_q + {{AW{1'b0}}, out_valid_q};
        s_tready    = (count < FULL_LEVEL);
        push        = s_tvalid & s_tready;
        pop         = out_valid_q & m_tready;
        // The output register refills from storage whenever it is empty or being popped.
        load        = (mem_count_q != '0) & (~out_valid_q | pop);

        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
        mem_count_d = mem_count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, load};
        out_valid_d = load | (out_valid_q & ~pop);
        out_data_d  = load ? mem_q[rd_ptr_q] : out_data_q;

        m_tdata     = out_data_q;
        m_tvalid    = out_valid_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: rtl/ad9361_rx_pair_packer.sv
// rtl/ad9361_rx_pair_packer.sv - pairs AD9361 channel strobes into packed, buffered 64-bit words
//
// Purpose: pairs channel-0 and channel-1 strobes of one RX frame, sign-extends each
// 12-bit component to 16 bits, buffers the packed word and streams it out.
// Ports:
//   clk, rst                   : RX sample clock, asynchronous active-high reset
//   en                         : capture enable; low forces pairing to IDLE
//   clr_stats                  : clears overflow, drop_count, misalign_count
//   valid_0, data_i0, data_q0  : channel-0 strobe and sample
//   valid_1, data_i1, data_q1  : channel-1 strobe and sample
//   m_axis                     : packed-word stream (m_data, m_valid, m_ready)
//   fifo_count                 : buffered words, output register included
//   overflow                   : sticky, set on any pair lost to a full FIFO
//   drop_count, misalign_count : saturating statistics
module ad9361_rx_pair_packer
    import ad9361_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          clr_stats,
    input  logic                          valid_0,
    input  logic [SAMPLE_W-1:0]           data_i0,
    input  logic [SAMPLE_W-1:0]           data_q0,
    input  logic                          valid_1,
    input  logic [SAMPLE_W-1:0]           data_i1,
    input  logic [SAMPLE_W-1:0]           data_q1,
    ad9361_rx_pair_packer_if.master       m_axis,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          drop_count,
    output logic [CNT_WIDTH-1:0]          misalign_count
);

    pair_state_e         state_q, state_d;
    logic [SAMPLE_W-1:0] held_i_q, held_i_d;
    logic [SAMPLE_W-1:0] held_q_q, held_q_d;
    logic                pack_valid_q, pack_valid_d;
    logic [PACK_W-1:0]   pack_data_q, pack_data_d;
    logic                overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
    logic [CNT_WIDTH-1:0] misalign_count_q, misalign_count_d;

    logic                pair_valid;
    logic [SAMPLE_W-1:0] pair_i0, pair_q0;
    logic                misalign_inc;
    logic                drop_inc;
    logic                fifo_s_tready;

    // Pairing FSM and pack stage.
    always_comb begin
        state_d      = state_q;
        held_i_d     = held_i_q;
        held_q_d     = held_q_q;
        pair_valid   = 1'b0;
        pair_i0      = data_i0;
        pair_q0      = data_q0;
        misalign_inc = 1'b0;

        if (!en) begin
            state_d  = IDLE;
            held_i_d = '0;
            held_q_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_0 && valid_1) begin
                        pair_valid = 1'b1;
                    end else if (valid_0) begin
                        held_i_d = data_i0;
                        held_q_d = data_q0;
                        state_d  = HALF;
                    end else if (valid_1) begin
                        misalign_inc = 1'b1;
                    end
                end
                HALF: begin
                    if (valid_1) begin
                        // Channel 1 closes the held half; a coincident channel 0 opens the next frame.
                        pair_valid = 1'b1;
                        pair_i0    = held_i_q;
                        pair_q0    = held_q_q;
                        if (valid_0) begin
                            held_i_d = data_i0;
                            held_q_d = data_q0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (valid_0) begin
                        held_i_d     = data_i0;
                        held_q_d     = data_q0;
                        misalign_inc = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        pack_valid_d = pair_valid;
        pack_data_d  = pair_valid ? {sign_ext(data_q1), sign_ext(data_i1),
                                     sign_ext(pair_q0), sign_ext(pair_i0)}
                                  : pack_data_q;
    end

    // Statistics; clr_stats overrides a coincident increment.
    always_comb begin
        drop_inc         = pack_valid_q & ~fifo_s_tready;
        overflow_d       = overflow_q;
        drop_count_d     = drop_count_q;
        misalign_count_d = misalign_count_q;

        if (clr_stats) begin
            overflow_d       = 1'b0;
            drop_count_d     = '0;
            misalign_count_d = '0;
        end else begin
            if (drop_inc) begin
                overflow_d = 1'b1;
                if (drop_count_q != '1) begin
                    drop_count_d = drop_count_q + CNT_WIDTH'(1);
                end
            end
            if (misalign_inc && (misalign_count_q != '1)) begin
                misalign_count_d = misalign_count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            held_i_q         <= '0;
            held_q_q         <= '0;
            pack_valid_q     <= 1'b0;
            pack_data_q      <= '0;
            overflow_q       <= 1'b0;
            drop_count_q     <= '0;
            misalign_count_q <= '0;
        end else begin
            state_q          <= state_d;
            held_i_q         <= held_i_d;
            held_q_q         <= held_q_d;
            pack_valid_q     <= pack_valid_d;
            pack_data_q      <= pack_data_d;
            overflow_q       <= overflow_d;
            drop_count_q     <= drop_count_d;
            misalign_count_q <= misalign_count_d;
        end
    end

    ad9361_sync_fifo #(
        .WIDTH (PACK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (pack_data_q),
        .s_tvalid (pack_valid_q),
        .s_tready (fifo_s_tready),
        .m_tdata  (m_axis.m_data),
        .m_tvalid (m_axis.m_valid),
        .m_tready (m_axis.m_ready),
        .count    (fifo_count)
    );

    assign overflow       = overflow_q;
    assign drop_count     = drop_count_q;
    assign misalign_count = misalign_count_q;

endmodule

// File: tb/tb_ad9361_rx_pair_packer.sv
// tb/tb_ad9361_rx_pair_packer.sv - directed self-checking bench for ad9361_rx_pair_packer
module tb_ad9361_rx_pair_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr_stats;
    logic        valid_0, valid_1;
    logic [11:0] data_i0, data_q0, data_i1, data_q1;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_count;
    logic [15:0] misalign_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] got_q[$];

    ad9361_rx_pair_packer_if m_if ();

    ad9361_rx_pair_packer #(
        .FIFO_DEPTH (16),
        .CNT_WIDTH  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .clr_stats      (clr_stats),
        .valid_0        (valid_0),
        .data_i0        (data_i0),
        .data_q0        (data_q0),
        .valid_1        (valid_1),
        .data_i1        (data_i1),
        .data_q1        (data_q1),
        .m_axis         (m_if),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .misalign_count (misalign_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic v0, input logic v1,
                          input logic [11:0] i0, input logic [11:0] q0,
                          input logic [11:0] i1, input logic [11:0] q1);
        valid_0 = v0;
        valid_1 = v1;
        data_i0 = i0;
        data_q0 = q0;
        data_i1 = i1;
        data_q1 = q1;
        tick();
        valid_0 = 1'b0;
        valid_1 = 1'b0;
    endtask

    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (m_if.m_valid && m_if.m_ready) got_q.push_back(m_if.m_data);
            tick();
        end
    endtask

    function automatic logic [63:0] burst_word(input int k);
        logic [15:0] w0, w1, w2, w3;
        w0 = 16'(k);
        w1 = 16'(k + 'h100);
        w2 = 16'(k + 'h200);
        w3 = 16'(k + 'h300);
        return {w3, w2, w1, w0};
    endfunction

    initial begin
        rst = 1'b1;
        en = 1'b1;
        clr_stats = 1'b0;
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        data_i0 = '0;
        data_q0 = '0;
        data_i1 = '0;
        data_q1 = '0;
        m_if.m_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_m_valid", 64'(m_if.m_valid), 64'd0);
        check("rst_m_data", m_if.m_data, 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_misalign", 64'(misalign_count), 64'd0);
        rst = 1'b0;
        tick();

        // Simultaneous strobes, latency and sign extension
        strobe(1'b1, 1'b1, 12'h7FF, 12'h800, 12'h001, 12'hFFF);
        check("simul_e0_valid", 64'(m_if.m_valid), 64'd0);
        tick();
        check("simul_e1_valid", 64'(m_if.m_valid), 64'd0);
        check("simul_e1_count", 64'(fifo_count), 64'd1);
        tick();
        check("simul_e2_valid", 64'(m_if.m_valid), 64'd1);
        check("simul_data", m_if.m_data, 64'hFFFF_0001_F800_07FF);
        tick();
        check("simul_popped_count", 64'(fifo_count), 64'd0);

        // Split strobes
        got_q.delete();
        strobe(1'b1, 1'b0, 12'h123, 12'h456, 12'h000, 12'h000);
        strobe(1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 12'h000);
        strobe(1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 12'h000);
        strobe(1'b0, 1'b1, 12'h000, 12'h000, 12'h9AB, 12'hCDE);
        drain(6);
        check("split_words", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check("split_data", got_q[0], 64'hFCDE_F9AB_0456_0123);
        check("split_misalign", 64'(misalign_count), 64'd0);

        // Misalignment: orphan ch1, then ch0 replaced, then paired
        got_q.delete();
        strobe(1'b0, 1'b1, 12'h000, 12'h000, 12'h111, 12'h222);
        strobe(1'b1, 1'b0, 12'h333, 12'h444, 12'h000, 12'h000);
        strobe(1'b1, 1'b0, 12'h555, 12'h666, 12'h000, 12'h000);
        strobe(1'b0, 1'b1, 12'h000, 12'h000, 12'h777, 12'h088);
        drain(6);
        check("mis_words", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check("mis_data", got_q[0], 64'h0088_0777_0666_0555);
        check("mis_count", 64'(misalign_count), 64'd2);

        // en low discards the held half silently; the later ch1 is an orphan
        got_q.delete();
        strobe(1'b1, 1'b0, 12'h0AA, 12'h0BB, 12'h000, 12'h000);
        en = 1'b0;
        tick();
        en = 1'b1;
        strobe(1'b0, 1'b1, 12'h000, 12'h000, 12'h0CC, 12'h0DD);
        drain(5);
        check("en_words", 64'(got_q.size()), 64'd0);
        check("en_misalign", 64'(misalign_count), 64'd3);

        // Overflow with m_ready low
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_misalign", 64'(misalign_count), 64'd0);
        m_if.m_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            valid_0 = 1'b1;
            valid_1 = 1'b1;
            data_i0 = 12'(k);
            data_q0 = 12'(k + 'h100);
            data_i1 = 12'(k + 'h200);
            data_q1 = 12'(k + 'h300);
            tick();
        end
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        repeat (3) tick();
        check("ovf_count", 64'(fifo_count), 64'd16);
        check("ovf_drop", 64'(drop_count), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_hold_data", m_if.m_data, burst_word(0));

        // clr_stats on the same edge as a drop
        strobe(1'b1, 1'b1, 12'h001, 12'h002, 12'h003, 12'h004);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_drop", 64'(drop_count), 64'd0);
        check("clr_overflow", 64'(overflow), 64'd0);
        tick();
        check("clr_drop_after", 64'(drop_count), 64'd0);
        check("clr_count_full", 64'(fifo_count), 64'd16);

        // Drain: first 16 pairs in order
        got_q.delete();
        m_if.m_ready = 1'b1;
        drain(20);
        check("drain_words", 64'(got_q.size()), 64'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < got_q.size()) check($sformatf("drain_word_%0d", k), got_q[k], burst_word(k));
        end
        check("drain_count", 64'(fifo_count), 64'd0);

        // Reset mid-burst with 5 words queued
        strobe(1'b0, 1'b1, 12'h000, 12'h000, 12'h010, 12'h020);
        m_if.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) strobe(1'b1, 1'b1, 12'(k), 12'h0, 12'h0, 12'h0);
        repeat (3) tick();
        check("pre_rst_count", 64'(fifo_count), 64'd5);
        check("pre_rst_misalign", 64'(misalign_count), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(m_if.m_valid), 64'd0);
        check("mid_rst_data", m_if.m_data, 64'd0);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_misalign", 64'(misalign_count), 64'd0);
        tick();
        rst = 1'b0;
        m_if.m_ready = 1'b1;
        tick();
        strobe(1'b1, 1'b1, 12'hABC, 12'h012, 12'h800, 12'h7FF);
        check("post_rst_e0_valid", 64'(m_if.m_valid), 64'd0);
        tick();
        check("post_rst_e1_valid", 64'(m_if.m_valid), 64'd0);
        tick();
        check("post_rst_e2_valid", 64'(m_if.m_valid), 64'd1);
        check("post_rst_data", m_if.m_data, 64'h07FF_F800_0012_FABC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
